// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: operation modes,
// FSM state encoding and a mode-classification helper.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_SRA  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m != MODE_HOLD) && (m != MODE_LOAD) && (m != MODE_CLR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate of a WIDTH-bit vector; reports the
// bit that leaves the vector. Non-shift modes pass the value through.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       mode,
    input  logic             sin,
    output logic [WIDTH-1:0] next_value,
    output logic             out_bit
);

    // One-position shift selected by mode
    always_comb begin
        next_value = value;
        out_bit    = 1'b0;
        case (mode)
            MODE_SHL: begin
                next_value = {value[WIDTH-2:0], sin};
                out_bit    = value[WIDTH-1];
            end
            MODE_SHR: begin
                next_value = {sin, value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_SRA: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                out_bit    = value[WIDTH-1];
            end
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                out_bit    = value[0];
            end
            default: begin
                next_value = value;
                out_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_n.sv
// WIDTH-bit universal shift register: single-cycle hold/load/clear and
// multi-cycle shifts/rotates sequenced by a start/busy/done handshake.
module shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    amount,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_r;
    logic [2:0]       mode_r;
    logic [AW-1:0]    cnt_r;
    logic [WIDTH-1:0] dout_r;
    logic             sout_r;
    logic             busy_r;
    logic             done_r;

    logic [AW-1:0]    count_s;
    logic [WIDTH-1:0] step_value_s;
    logic             step_out_s;

    // Shift count saturates at WIDTH
    always_comb begin
        if (amount > AW'(WIDTH)) begin
            count_s = AW'(WIDTH);
        end else begin
            count_s = amount;
        end
    end

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value     (dout_r),
        .mode      (mode_r),
        .sin       (sin),
        .next_value(step_value_s),
        .out_bit   (step_out_s)
    );

    // FSM, shift counter and all output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_HOLD;
            cnt_r   <= '0;
            dout_r  <= '0;
            sout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (is_shift_mode(mode) && (count_s != '0)) begin
                            state_r <= ST_SHIFT;
                            busy_r  <= 1'b1;
                            mode_r  <= mode;
                            cnt_r   <= count_s;
                        end else begin
                            done_r <= 1'b1;
                            case (mode)
                                MODE_LOAD: dout_r <= din;
                                MODE_CLR:  dout_r <= '0;
                                default:   dout_r <= dout_r;
                            endcase
                        end
                    end
                end
                ST_SHIFT: begin
                    dout_r <= step_value_s;
                    sout_r <= step_out_s;
                    cnt_r  <= cnt_r - AW'(1);
                    if (cnt_r == AW'(1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = dout_r;
    assign sout = sout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_reg_n.sv
// Scoreboard bench for shift_reg_n (WIDTH = 8): directed operations push
// expected per-shift and completion results; a monitor pops and compares.
module tb_shift_reg_n;
    import shift_reg_pkg::*;

    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH) + 1;

    typedef struct {
        logic [7:0] dout;
        logic       sout;
    } step_t;

    typedef struct {
        logic [7:0] dout;
        logic       sout;
        int         cycles;
    } done_t;

    logic             clk;
    logic             reset;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    amount;
    logic             sin;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic             busy;
    logic             done;

    step_t step_q[$];
    done_t done_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    shift_reg_n #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .din   (din),
        .amount(amount),
        .sin   (sin),
        .dout  (dout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: output seen with no expectation queued", name);
    endtask

    // Monitor: pops on every shift edge and on every done pulse
    initial begin : monitor
        logic  prev_busy;
        int    busy_run;
        step_t s;
        done_t d;
        prev_busy = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_busy = 1'b0;
                busy_run  = 0;
            end else begin
                if (prev_busy) begin
                    if (step_q.size() == 0) begin
                        unexpected("step");
                    end else begin
                        s = step_q.pop_front();
                        check("step_dout", 32'(dout), 32'(s.dout));
                        check("step_sout", 32'(sout), 32'(s.sout));
                    end
                end
                if (busy) busy_run++;
                if (done) begin
                    if (done_q.size() == 0) begin
                        unexpected("done");
                    end else begin
                        d = done_q.pop_front();
                        check("done_dout", 32'(dout), 32'(d.dout));
                        check("done_sout", 32'(sout), 32'(d.sout));
                        check("done_busy", 32'(busy), 32'd0);
                        check("busy_cycles", 32'(busy_run), 32'(d.cycles));
                    end
                    busy_run = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic push_step(input logic [7:0] v, input logic o);
        step_t s;
        s.dout = v;
        s.sout = o;
        step_q.push_back(s);
    endtask

    task automatic push_done(input logic [7:0] v, input logic o, input int c);
        done_t d;
        d.dout   = v;
        d.sout   = o;
        d.cycles = c;
        done_q.push_back(d);
    endtask

    task automatic issue(input logic [2:0] m, input logic [7:0] d, input logic [AW-1:0] a);
        start  = 1'b1;
        mode   = m;
        din    = d;
        amount = a;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: done not seen within 40 cycles", name);
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset  = 1'b1;
        start  = 1'b0;
        mode   = MODE_HOLD;
        din    = 8'h00;
        amount = 4'd0;
        sin    = 1'b0;
        #3;
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_sout", 32'(sout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        push_done(8'hA5, 1'b0, 0);
        issue(MODE_LOAD, 8'hA5, 4'd0);
        wait_done("load");

        push_step(8'h4B, 1'b1);
        push_step(8'h96, 1'b0);
        push_step(8'h2D, 1'b1);
        push_done(8'h2D, 1'b1, 3);
        issue(MODE_ROL, 8'h00, 4'd3);
        wait_done("rol");

        push_done(8'h90, 1'b1, 0);
        issue(MODE_LOAD, 8'h90, 4'd0);
        wait_done("load90");
        push_step(8'hC8, 1'b0);
        push_step(8'hE4, 1'b0);
        push_done(8'hE4, 1'b0, 2);
        issue(MODE_SRA, 8'h00, 4'd2);
        wait_done("sra");

        push_done(8'h00, 1'b0, 0);
        issue(MODE_CLR, 8'h00, 4'd0);
        wait_done("clr");
        sin = 1'b1;
        push_step(8'h01, 1'b0);
        push_step(8'h03, 1'b0);
        push_step(8'h07, 1'b0);
        push_step(8'h0F, 1'b0);
        push_step(8'h1F, 1'b0);
        push_step(8'h3F, 1'b0);
        push_step(8'h7F, 1'b0);
        push_step(8'hFF, 1'b0);
        push_done(8'hFF, 1'b0, 8);
        issue(MODE_SHL, 8'h00, 4'd12);
        wait_done("shl_sat");
        sin = 1'b0;
        push_done(8'hFF, 1'b0, 0);
        issue(MODE_SHR, 8'h00, 4'd0);
        wait_done("shr_zero");

        // Clear command arriving while a rotate is running must be dropped
        push_done(8'h3C, 1'b0, 0);
        issue(MODE_LOAD, 8'h3C, 4'd0);
        wait_done("load3c");
        push_step(8'h1E, 1'b0);
        push_step(8'h0F, 1'b0);
        push_step(8'h87, 1'b1);
        push_step(8'hC3, 1'b1);
        push_done(8'hC3, 1'b1, 4);
        start  = 1'b1;
        mode   = MODE_ROR;
        amount = 4'd4;
        @(posedge clk);
        #1;
        mode = MODE_CLR;
        din  = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ror_busy_start");

        push_done(8'h81, 1'b1, 0);
        issue(MODE_LOAD, 8'h81, 4'd0);
        wait_done("load81");
        push_step(8'h02, 1'b1);
        push_step(8'h04, 1'b0);
        issue(MODE_SHL, 8'h00, 4'd5);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_dout", 32'(dout), 32'h00);
        check("abort_sout", 32'(sout), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("step_q_empty", 32'(step_q.size()), 32'd0);
        check("done_q_empty", 32'(done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
